// File: rtl/aes_key_expander_seq_if.sv
// rtl/aes_key_expander_seq_if.sv - start/key request and expanded-word stream bundle for aes_key_expander_seq
interface aes_key_expander_seq_if #(
  parameter int IDX_W = 6
);
  logic             start;
  logic [1:0]       key_len;
  logic [0:255]     key_in;
  logic             word_valid;
  logic             word_ready;
  logic [0:31]      word_out;
  logic [IDX_W-1:0] word_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, key_len, key_in, word_ready,
    input  word_valid, word_out, word_idx, busy, done, err
  );

  modport slave (
    input  start, key_len, key_in, word_ready,
    output word_valid, word_out, word_idx, busy, done, err
  );
endinterface

// File: rtl/aes_key_expander_seq.sv
// rtl/aes_key_expander_seq.sv - sequential AES-128/192/256 key expander, one expanded word per handshake
module aes_key_expander_seq #(
  parameter bit EN_192 = 1'b1,
  parameter bit EN_256 = 1'b1,
  parameter int IDX_W  = 6
) (
  input logic                  clk,
  input logic                  rst,
  aes_key_expander_seq_if.slave kif
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    logic [0:31] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox(w[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t           state_q, state_d;
  logic [0:31]      win_q [8];
  logic [0:31]      win_d [8];
  logic [0:31]      word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d, nk_q, nk_d, nwm1_q, nwm1_d;
  logic [2:0]       kcnt_q, kcnt_d, nkm1_q, nkm1_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             hs, key_len_ok, rot_sel, sub_only;
  logic [IDX_W-1:0] idx_n;
  logic [2:0]       kcnt_n;
  logic [0:31]      sub_in, sub_out, t_word;

  assign hs         = valid_q & kif.word_ready;
  assign key_len_ok = (kif.key_len == 2'b00) || (kif.key_len == 2'b01 && EN_192) ||
                      (kif.key_len == 2'b10 && EN_256);
  assign idx_n      = idx_q + IDX_W'(1);
  assign kcnt_n     = (kcnt_q == nkm1_q) ? 3'd0 : kcnt_q + 3'd1;

  // The one shared SubWord path: its input is rotated only on the i mod Nk == 0 step.
  assign rot_sel  = (kcnt_n == 3'd0);
  assign sub_only = (nkm1_q == 3'd7) && (kcnt_n == 3'd4);
  assign sub_in   = rot_sel ? {word_q[8:31], word_q[0:7]} : word_q;
  assign sub_out  = sub_word(sub_in);
  assign t_word   = rot_sel  ? (sub_out ^ {rcon_q, 24'h000000}) :
                    sub_only ? sub_out : word_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    word_d  = word_q;
    idx_d   = idx_q;
    nk_d    = nk_q;
    nwm1_d  = nwm1_q;
    nkm1_d  = nkm1_q;
    kcnt_d  = kcnt_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kif.start) begin
          if (key_len_ok) begin
            for (int j = 0; j < 8; j++) win_d[j] = kif.key_in[32*j +: 32];
            word_d  = kif.key_in[0:31];
            idx_d   = '0;
            kcnt_d  = 3'd0;
            rcon_d  = 8'h01;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_EMIT;
            case (kif.key_len)
              2'b01:   begin nk_d = IDX_W'(6); nkm1_d = 3'd5; nwm1_d = IDX_W'(51); end
              2'b10:   begin nk_d = IDX_W'(8); nkm1_d = 3'd7; nwm1_d = IDX_W'(59); end
              default: begin nk_d = IDX_W'(4); nkm1_d = 3'd3; nwm1_d = IDX_W'(43); end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (idx_q == nwm1_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d  = idx_n;
            kcnt_d = kcnt_n;
            // Window holds w[i-Nk..i-1] once derived words start; raw key words are read in place.
            if (idx_q >= nk_q) begin
              for (int j = 0; j < 7; j++) begin
                if (3'(j) < nkm1_q) win_d[j] = win_q[j+1];
              end
              win_d[nkm1_q] = word_q;
            end
            if (idx_n < nk_q) begin
              word_d = win_q[idx_n[2:0]];
            end else begin
              word_d = win_d[0] ^ t_word;
              if (rot_sel) rcon_d = xtime(rcon_q);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      nk_q    <= '0;
      nwm1_q  <= '0;
      nkm1_q  <= '0;
      kcnt_q  <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      nk_q    <= nk_d;
      nwm1_q  <= nwm1_d;
      nkm1_q  <= nkm1_d;
      kcnt_q  <= kcnt_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign kif.word_valid = valid_q;
  assign kif.word_out   = word_q;
  assign kif.word_idx   = idx_q;
  assign kif.busy       = busy_q;
  assign kif.done       = done_q;
  assign kif.err        = err_q;
endmodule

// File: tb/tb_aes_key_expander_seq.sv
// tb/tb_aes_key_expander_seq.sv - directed FIPS-197 vector bench for aes_key_expander_seq
module tb_aes_key_expander_seq;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expander_seq_if #(.IDX_W(6)) kif ();
  aes_key_expander_seq_if #(.IDX_W(6)) kif2 ();

  aes_key_expander_seq #(.EN_192(1'b1), .EN_256(1'b1), .IDX_W(6)) u_dut (
    .clk(clk), .rst(rst), .kif(kif)
  );
  aes_key_expander_seq #(.EN_192(1'b0), .EN_256(1'b1), .IDX_W(6)) u_dut_no192 (
    .clk(clk), .rst(rst), .kif(kif2)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  logic [31:0] exp128 [60];
  logic [31:0] exp192 [60];
  logic [31:0] exp256 [60];
  logic [31:0] got_word [64];
  int nhs, done_cyc, first_valid_c, stall_bad, n_stalls, idx_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference S-box from the field inverse plus affine map, independent of any lookup table.
  task automatic init_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic start_key(input logic [1:0] len, input logic [255:0] key);
    logic [255:0] g;
    kif.start   = 1'b1;
    kif.key_len = len;
    kif.key_in  = key;
    tick();
    kif.start = 1'b0;
    for (int j = 0; j < 8; j++) g[32*j +: 32] = $urandom;
    kif.key_in  = g;
    kif.key_len = 2'b11;
  endtask

  task automatic collect(input bit rnd, input int budget);
    logic [31:0] pw;
    logic [5:0]  pi;
    bit pstall, rdy;
    nhs = 0; done_cyc = -1; first_valid_c = -1; stall_bad = 0; n_stalls = 0; idx_bad = 0;
    pstall = 1'b0; pw = '0; pi = '0;
    for (int i = 0; i < 64; i++) got_word[i] = 'x;
    for (int c = 1; c <= budget; c++) begin
      if (pstall && (kif.word_valid !== 1'b1 || kif.word_out !== pw || kif.word_idx !== pi))
        stall_bad++;
      if (kif.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (kif.word_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      kif.word_ready = rdy;
      pstall = (kif.word_valid === 1'b1) && !rdy;
      if (pstall) begin
        pw = kif.word_out;
        pi = kif.word_idx;
        n_stalls++;
      end
      if (kif.word_valid === 1'b1 && rdy) begin
        if (kif.word_idx !== 6'(nhs)) idx_bad++;
        if (nhs < 64) got_word[nhs] = kif.word_out;
        nhs++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (kif.word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", kif.word_valid); end
    checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", kif.busy); end
    checks++; if (kif.done !== 1'b0 || kif.err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", kif.done, kif.err); end
    checks++; if (kif.word_out !== 32'h0 || kif.word_idx !== 6'd0) begin failures++; $display("FAIL reset_word got=%h/%0d exp=0/0", kif.word_out, kif.word_idx); end
  endtask

  task automatic test_aes128();
    start_key(2'b00, K128);
    checks++; if (kif.busy !== 1'b1) begin failures++; $display("FAIL a128_busy got=%b exp=1", kif.busy); end
    collect(1'b0, 200);
    checks++; if (first_valid_c !== 1) begin failures++; $display("FAIL a128_first_valid got=%0d exp=1", first_valid_c); end
    checks++; if (done_cyc !== 45) begin failures++; $display("FAIL a128_done_cycle got=%0d exp=45", done_cyc); end
    checks++; if (nhs !== 44 || idx_bad !== 0) begin failures++; $display("FAIL a128_count got=%0d badidx=%0d exp=44/0", nhs, idx_bad); end
    checks++; if (got_word[0] !== 32'h2b7e1516) begin failures++; $display("FAIL a128_w0 got=%h exp=2b7e1516", got_word[0]); end
    checks++; if (got_word[4] !== 32'ha0fafe17) begin failures++; $display("FAIL a128_w4 got=%h exp=a0fafe17", got_word[4]); end
    checks++; if (got_word[43] !== 32'hb6630ca6) begin failures++; $display("FAIL a128_w43 got=%h exp=b6630ca6", got_word[43]); end
    for (int i = 0; i < 44; i++) begin
      checks++; if (got_word[i] !== exp128[i]) begin failures++; $display("FAIL a128_model_w%0d got=%h exp=%h", i, got_word[i], exp128[i]); end
    end
    tick();
    checks++; if (kif.done !== 1'b0 || kif.busy !== 1'b0) begin failures++; $display("FAIL a128_after_done got=%b%b exp=00", kif.done, kif.busy); end
  endtask

  task automatic test_aes192();
    start_key(2'b01, K192);
    collect(1'b0, 200);
    checks++; if (nhs !== 52 || idx_bad !== 0) begin failures++; $display("FAIL a192_count got=%0d badidx=%0d exp=52/0", nhs, idx_bad); end
    checks++; if (done_cyc !== 53) begin failures++; $display("FAIL a192_done_cycle got=%0d exp=53", done_cyc); end
    checks++; if (got_word[6] !== 32'hfe0c91f7) begin failures++; $display("FAIL a192_w6 got=%h exp=fe0c91f7", got_word[6]); end
    checks++; if (got_word[51] !== 32'h01002202) begin failures++; $display("FAIL a192_w51 got=%h exp=01002202", got_word[51]); end
    for (int i = 0; i < 52; i++) begin
      checks++; if (got_word[i] !== exp192[i]) begin failures++; $display("FAIL a192_model_w%0d got=%h exp=%h", i, got_word[i], exp192[i]); end
    end
    tick();
  endtask

  task automatic test_aes256();
    start_key(2'b10, K256);
    collect(1'b0, 200);
    checks++; if (nhs !== 60 || idx_bad !== 0) begin failures++; $display("FAIL a256_count got=%0d badidx=%0d exp=60/0", nhs, idx_bad); end
    checks++; if (done_cyc !== 61) begin failures++; $display("FAIL a256_done_cycle got=%0d exp=61", done_cyc); end
    checks++; if (got_word[8] !== 32'h9ba35411) begin failures++; $display("FAIL a256_w8 got=%h exp=9ba35411", got_word[8]); end
    checks++; if (got_word[12] !== 32'ha8b09c1a) begin failures++; $display("FAIL a256_w12 got=%h exp=a8b09c1a", got_word[12]); end
    checks++; if (got_word[59] !== 32'h706c631e) begin failures++; $display("FAIL a256_w59 got=%h exp=706c631e", got_word[59]); end
    tick();
  endtask

  task automatic test_random_ready();
    start_key(2'b10, K256);
    collect(1'b1, 1000);
    checks++; if (nhs !== 60 || idx_bad !== 0) begin failures++; $display("FAIL rnd_count got=%0d badidx=%0d exp=60/0", nhs, idx_bad); end
    checks++; if (done_cyc < 0) begin failures++; $display("FAIL rnd_done_timeout got=%0d exp=done", done_cyc); end
    checks++; if (stall_bad !== 0 || n_stalls == 0) begin failures++; $display("FAIL rnd_stall_stable got=%0d of %0d stalls exp=0 changed", stall_bad, n_stalls); end
    for (int i = 0; i < 60; i++) begin
      checks++; if (got_word[i] !== exp256[i]) begin failures++; $display("FAIL rnd_model_w%0d got=%h exp=%h", i, got_word[i], exp256[i]); end
    end
    tick();
  endtask

  task automatic test_illegal();
    kif.key_len  = 2'b11;
    kif.key_in   = K128;
    kif.start    = 1'b1;
    kif2.key_len = 2'b01;
    kif2.key_in  = K192;
    kif2.start   = 1'b1;
    tick();
    kif.start  = 1'b0;
    kif2.start = 1'b0;
    checks++; if (kif.err !== 1'b1 || kif.busy !== 1'b0) begin failures++; $display("FAIL ill11_err got=%b busy=%b exp=1/0", kif.err, kif.busy); end
    checks++; if (kif2.err !== 1'b1 || kif2.busy !== 1'b0) begin failures++; $display("FAIL no192_err got=%b busy=%b exp=1/0", kif2.err, kif2.busy); end
    tick();
    checks++; if (kif.err !== 1'b0 || kif.word_valid !== 1'b0) begin failures++; $display("FAIL ill11_after got=err%b valid%b exp=00", kif.err, kif.word_valid); end
    checks++; if (kif2.err !== 1'b0 || kif2.word_valid !== 1'b0) begin failures++; $display("FAIL no192_after got=err%b valid%b exp=00", kif2.err, kif2.word_valid); end
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    start_key(2'b00, K128);
    kif.word_ready = 1'b1;
    for (int c = 0; c < 100 && kif.word_idx !== 6'd20; c++) tick();
    checks++; if (kif.word_idx !== 6'd20) begin failures++; $display("FAIL abort_reach_idx got=%0d exp=20", kif.word_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({kif.word_valid, kif.busy, kif.done, kif.err, kif.word_out, kif.word_idx} !== 42'h0) begin
      failures++;
      $display("FAIL abort_outputs got=v%b b%b d%b e%b %h/%0d exp=all 0", kif.word_valid, kif.busy, kif.done, kif.err, kif.word_out, kif.word_idx);
    end
    for (int c = 0; c < 50; c++) begin
      if (kif.done === 1'b1 || kif.word_valid === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d cycles exp=0", done_seen); end
    start_key(2'b00, K128);
    checks++; if (kif.word_valid !== 1'b1 || kif.word_idx !== 6'd0 || kif.word_out !== 32'h2b7e1516) begin
      failures++;
      $display("FAIL restart_w0 got=v%b %h/%0d exp=1 2b7e1516/0", kif.word_valid, kif.word_out, kif.word_idx);
    end
    kif.word_ready = 1'b0;
    start_key(2'b10, K256);
    collect(1'b0, 200);
    checks++; if (nhs !== 44 || idx_bad !== 0) begin failures++; $display("FAIL busy_start_count got=%0d badidx=%0d exp=44/0", nhs, idx_bad); end
    checks++; if (got_word[43] !== 32'hb6630ca6) begin failures++; $display("FAIL busy_start_w43 got=%h exp=b6630ca6", got_word[43]); end
    tick();
  endtask

  initial begin
    kif.start = 1'b0; kif.key_len = 2'b00; kif.key_in = '0; kif.word_ready = 1'b0;
    kif2.start = 1'b0; kif2.key_len = 2'b00; kif2.key_in = '0; kif2.word_ready = 1'b1;
    init_sbox();
    model_expand(K128, 4); exp128 = mw;
    model_expand(K192, 6); exp192 = mw;
    model_expand(K256, 8); exp256 = mw;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_random_ready();
    test_illegal();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
